// File: rtl/svi_arb_pkg.sv
// rtl/svi_arb_pkg.sv - shared types, constants and round-robin pick function for the write arbiter
package svi_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // First set request bit at or above ptr, wrapping. Bits above N_REQ are
  // expected to be zero, so wrapping modulo MAX_REQ matches wrapping modulo
  // N_REQ. Returns ptr when nothing is requested.
  function automatic logic [OWNER_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [OWNER_W-1:0] ptr);
    logic [OWNER_W-1:0] idx;
    logic               found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + OWNER_W'(i);
      if (req[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/svi_write_arbiter_if.sv
// rtl/svi_write_arbiter_if.sv - request/grant and shared x/y bus between requesters and the arbiter
interface svi_write_arbiter_if
  import svi_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   i_req;
  logic [N_REQ-1:0]   i_x;
  logic [N_REQ-1:0]   i_y;
  logic [N_REQ-1:0]   o_gnt;
  logic               o_x;
  logic               o_y;
  logic [OWNER_W-1:0] o_owner;
  logic               o_busy;

  // Requester side drives requests and data, observes grant and shared bus.
  modport master (
    output i_req, i_x, i_y,
    input  o_gnt, o_x, o_y, o_owner, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_x, i_y,
    output o_gnt, o_x, o_y, o_owner, o_busy
  );

endinterface

// File: rtl/svi_arb_rr_pick.sv
// rtl/svi_arb_rr_pick.sv - combinational round-robin winner picker
module svi_arb_rr_pick
  import svi_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               valid
);

  logic [MAX_REQ-1:0] req_ext;

  assign req_ext = MAX_REQ'(req);
  assign winner  = rr_pick(req_ext, ptr);
  assign valid   = |req;

endmodule

// File: rtl/svi_write_arbiter.sv
// rtl/svi_write_arbiter.sv - round-robin write arbiter for shared x/y members; optional hold timeout via SVI_ARB_TIMEOUT_EN
module svi_write_arbiter
  import svi_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic               i_sclk,
  input  logic               i_srst,
  svi_write_arbiter_if.slave bus
);

  arb_state_t         state_q, state_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               x_q, x_d;
  logic               y_q, y_d;
  logic               busy_q, busy_d;

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] x_ext;
  logic [MAX_REQ-1:0] y_ext;
  logic [OWNER_W-1:0] win_idx;
  logic               win_valid;
  logic               hold_expired;

  // Widen to MAX_REQ so the 3-bit owner index can address them directly.
  assign req_ext = MAX_REQ'(bus.i_req);
  assign x_ext   = MAX_REQ'(bus.i_x);
  assign y_ext   = MAX_REQ'(bus.i_y);

  svi_arb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (bus.i_req),
    .ptr    (ptr_q),
    .winner (win_idx),
    .valid  (win_valid)
  );

`ifdef SVI_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  // Hold counter: zero while idle so it is clear on GRANT entry, counts GRANT cycles.
  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE) begin
      hold_d = 8'd0;
    end else if (state_q == GRANT) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // The edge that would start cycle HOLD_MAX+1 of the grant revokes it instead.
  assign hold_expired = ((9'(hold_q) + 9'd1) >= 9'(HOLD_MAX));

  // Hold counter register.
  always_ff @(posedge i_sclk) begin
    if (i_srst) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic [7:0] unused_hold_max;
  assign unused_hold_max = 8'(HOLD_MAX);
  assign hold_expired    = 1'b0;
`endif

  // Next-state and registered-output computation for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = GRANT;
          owner_d = win_idx;
          busy_d  = 1'b1;
          ptr_d   = (win_idx == OWNER_W'(N_REQ - 1)) ? '0 : win_idx + OWNER_W'(1);
          for (int i = 0; i < N_REQ; i++) begin
            gnt_d[i] = (win_idx == OWNER_W'(i));
          end
        end
      end
      GRANT: begin
        x_d = x_ext[owner_q];
        y_d = y_ext[owner_q];
        if (!req_ext[owner_q] || hold_expired) begin
          state_d = TURN;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and output registers; reset wins over everything, including mid-grant.
  always_ff @(posedge i_sclk) begin
    if (i_srst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_x     = x_q;
  assign bus.o_y     = y_q;
  assign bus.o_owner = owner_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_svi_write_arbiter.sv
// tb/tb_svi_write_arbiter.sv - directed scoreboard bench for svi_write_arbiter
module tb_svi_write_arbiter;

  localparam int N_REQ    = 4;
  localparam int HOLD_MAX = 4;

  logic clk  = 1'b0;
  logic srst = 1'b1;

  always #5 clk = ~clk;

  svi_write_arbiter_if #(.N_REQ(N_REQ)) bus ();

  svi_write_arbiter #(
    .N_REQ    (N_REQ),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .i_sclk (clk),
    .i_srst (srst),
    .bus    (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       x;
    logic       y;
    logic [2:0] owner;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of requests, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] egnt,
                      input logic ex, input logic ey, input logic [2:0] eown);
    exp_t e_in;
    exp_t e;
    bus.i_req = req;
    e_in = '{tag: tag, gnt: egnt, x: ex, y: ey, owner: eown};
    sbq.push_back(e_in);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_underflow"}, 8'd0, 8'd1);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_gnt"},  8'(bus.o_gnt),  8'(e.gnt));
      chk({e.tag, "_x"},    8'(bus.o_x),    8'(e.x));
      chk({e.tag, "_y"},    8'(bus.o_y),    8'(e.y));
      chk({e.tag, "_busy"}, 8'(bus.o_busy), 8'(e.gnt != 4'd0));
      chk({e.tag, "_oh"},   8'($onehot0(bus.o_gnt)), 8'd1);
      if (e.gnt != 4'd0) begin
        chk({e.tag, "_owner"}, 8'(bus.o_owner), 8'(e.owner));
      end
    end
  endtask

  logic [3:0] xpat;
  logic [3:0] ypat;
  logic       cur_x;
  logic       cur_y;

  initial begin
    bus.i_req = '0;
    bus.i_x   = '0;
    bus.i_y   = '0;
    #1;

    // Reset values.
    srst = 1'b1;
    step("rst", 4'b0000, 4'b0000, 1'b0, 1'b1, 3'd0);
    chk("rst_ptr", 8'(dut.ptr_q), 8'd0);
    srst = 1'b0;

    // Data steering for requester 1, then hold through TURN/IDLE.
    bus.i_x = 4'b0010;
    bus.i_y = 4'b0000;
    step("steer_gnt",  4'b0010, 4'b0010, 1'b0, 1'b1, 3'd1);
    chk("steer_ptr", 8'(dut.ptr_q), 8'd2);
    step("steer_data", 4'b0010, 4'b0010, 1'b1, 1'b0, 3'd1);
    step("steer_rel",  4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);
    bus.i_x = 4'b0000;
    bus.i_y = 4'b1111;
    step("steer_turn", 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);
    step("steer_idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);

    // Move ptr to 3, then wrap to requester 0.
    step("w_gnt2", 4'b0100, 4'b0100, 1'b1, 1'b0, 3'd2);
    chk("w_ptr3", 8'(dut.ptr_q), 8'd3);
    step("w_rel2",  4'b0000, 4'b0000, 1'b0, 1'b1, 3'd0);
    step("w_turn2", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd0);
    chk("w_ptr3_turn", 8'(dut.ptr_q), 8'd3);
    step("w_gnt0", 4'b0001, 4'b0001, 1'b0, 1'b1, 3'd0);
    chk("w_ptr1", 8'(dut.ptr_q), 8'd1);
    // Non-owner request during GRANT and TURN is ignored.
    step("w_other", 4'b0011, 4'b0001, 1'b0, 1'b1, 3'd0);
    step("w_rel0",  4'b0010, 4'b0000, 1'b0, 1'b1, 3'd0);
    step("w_turn0", 4'b0010, 4'b0000, 1'b0, 1'b1, 3'd0);
    step("w_gnt1",  4'b0010, 4'b0010, 1'b0, 1'b1, 3'd1);
    step("w_rel1",  4'b0000, 4'b0000, 1'b0, 1'b1, 3'd0);
    step("w_turn1", 4'b0000, 4'b0000, 1'b0, 1'b1, 3'd0);

    // Reset in the middle of a grant to requester 2.
    bus.i_x = 4'b0100;
    bus.i_y = 4'b0000;
    step("mr_gnt2", 4'b0100, 4'b0100, 1'b0, 1'b1, 3'd2);
    step("mr_hold", 4'b0100, 4'b0100, 1'b1, 1'b0, 3'd2);
    srst = 1'b1;
    step("mr_rst",  4'b0100, 4'b0000, 1'b0, 1'b1, 3'd0);
    chk("mr_ptr0", 8'(dut.ptr_q), 8'd0);
    srst = 1'b0;
    step("mr_first", 4'b0100, 4'b0100, 1'b0, 1'b1, 3'd2);
    step("mr_rel",   4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);
    step("mr_turn",  4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);

    // Round-robin rotation 0,1,2,3,0 with all requesting.
    srst = 1'b1;
    step("rr_rst", 4'b0000, 4'b0000, 1'b0, 1'b1, 3'd0);
    srst = 1'b0;
    xpat = 4'b0101;
    ypat = 4'b0011;
    bus.i_x = xpat;
    bus.i_y = ypat;
    cur_x = 1'b0;
    cur_y = 1'b1;
    for (int r = 0; r < 5; r++) begin
      int k;
      k = r % 4;
      step($sformatf("rr_gnt%0d", r), 4'b1111, 4'(1 << k), cur_x, cur_y, 3'(k));
      chk($sformatf("rr_ptr%0d", r), 8'(dut.ptr_q), 8'((k + 1) % 4));
      cur_x = xpat[k];
      cur_y = ypat[k];
      step($sformatf("rr_rel%0d", r),  4'b1111 & ~4'(1 << k), 4'b0000, cur_x, cur_y, 3'd0);
      step($sformatf("rr_turn%0d", r), 4'b1111, 4'b0000, cur_x, cur_y, 3'd0);
    end

    // Long hold with a competing requester.
    srst = 1'b1;
    step("h_rst", 4'b0000, 4'b0000, 1'b0, 1'b1, 3'd0);
    srst = 1'b0;
    bus.i_x = 4'b0000;
    bus.i_y = 4'b1111;
`ifdef SVI_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step($sformatf("to0_c%0d", c), 4'b0011, 4'b0001, 1'b0, 1'b1, 3'd0);
    end
    step("to0_turn", 4'b0011, 4'b0000, 1'b0, 1'b1, 3'd0);
    step("to0_idle", 4'b0011, 4'b0000, 1'b0, 1'b1, 3'd0);
    for (int c = 0; c < 4; c++) begin
      step($sformatf("to1_c%0d", c), 4'b0011, 4'b0010, 1'b0, 1'b1, 3'd1);
    end
    step("to1_turn", 4'b0011, 4'b0000, 1'b0, 1'b1, 3'd0);
`else
    step("nt_gnt", 4'b0011, 4'b0001, 1'b0, 1'b1, 3'd0);
    for (int c = 0; c < 100; c++) begin
      step($sformatf("nt_c%0d", c), 4'b0011, 4'b0001, 1'b0, 1'b1, 3'd0);
    end
`endif

    chk("sb_empty", 8'(sbq.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
